// File: rtl/ram_port_arbiter_if.sv
// rtl/ram_port_arbiter_if.sv - requester-side request/ack port of the RAM arbiter
interface ram_port_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6
) ();
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  // Requester side: raises req with we/addr/wdata, waits for the ack pulse.
  modport master (output req, we, addr, wdata, input ack, rdata);
  // Arbiter side.
  modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - two-port arbiter/sequencer for the 64x16 data RAM
// Optional macro ARB_ROUND_ROBIN_EN: round-robin tie break instead of fixed A>B priority.
module ram_port_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6
) (
  input  logic                clk,
  input  logic                reset,
  ram_port_arbiter_if.slave   a,
  ram_port_arbiter_if.slave   b,
  output logic                ram_mem_read,
  output logic                ram_mem_write,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_write_data,
  input  logic [DATA_W-1:0]   ram_read_data,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state;
  logic              lat_we;
  logic              lat_owner;   // 0 = port A, 1 = port B
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              mem_read_q;
  logic              mem_write_q;
  logic              busy_q;
  logic              a_ack_q;
  logic              b_ack_q;
  logic [DATA_W-1:0] a_rdata_q;
  logic [DATA_W-1:0] b_rdata_q;

  logic              grant_b;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_winner;  // 0 = A, 1 = B
  // On a tie the port that did not win last time takes the grant.
  assign grant_b = b.req & (~a.req | ~last_winner);
`else
  // Fixed priority: B only wins when A is not asking.
  assign grant_b = b.req & ~a.req;
`endif

  assign sel_we    = grant_b ? b.we    : a.we;
  assign sel_addr  = grant_b ? b.addr  : a.addr;
  assign sel_wdata = grant_b ? b.wdata : a.wdata;

  // Sequencer: IDLE latches the winner, ACCESS strobes the RAM, RESP acks.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      lat_we      <= 1'b0;
      lat_owner   <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      busy_q      <= 1'b0;
      a_ack_q     <= 1'b0;
      b_ack_q     <= 1'b0;
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_winner <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          a_ack_q <= 1'b0;
          b_ack_q <= 1'b0;
          if (a.req || b.req) begin
            lat_owner   <= grant_b;
            lat_we      <= sel_we;
            addr_q      <= sel_addr;
            wdata_q     <= sel_wdata;
            mem_read_q  <= ~sel_we;
            mem_write_q <= sel_we;
            busy_q      <= 1'b1;
            state       <= ACCESS;
`ifdef ARB_ROUND_ROBIN_EN
            last_winner <= grant_b;
`endif
          end
        end
        ACCESS: begin
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b0;
          if (!lat_we) begin
            if (lat_owner) b_rdata_q <= ram_read_data;
            else           a_rdata_q <= ram_read_data;
          end
          if (lat_owner) b_ack_q <= 1'b1;
          else           a_ack_q <= 1'b1;
          state <= RESP;
        end
        RESP: begin
          a_ack_q <= 1'b0;
          b_ack_q <= 1'b0;
          busy_q  <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The write strobe is masked by reset so a reset during ACCESS never commits.
  assign ram_mem_write  = mem_write_q & ~reset;
  assign ram_mem_read   = mem_read_q;
  assign ram_addr       = addr_q;
  assign ram_write_data = wdata_q;
  assign busy           = busy_q;
  assign a.ack          = a_ack_q;
  assign a.rdata        = a_rdata_q;
  assign b.ack          = b_ack_q;
  assign b.rdata        = b_rdata_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - scoreboard bench for ram_port_arbiter
module tb_ram_port_arbiter;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 6;

  typedef struct {
    logic        port;
    logic        chk_data;
    logic [15:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic ram_mem_read, ram_mem_write, busy;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_write_data, ram_read_data;
  logic [DATA_W-1:0] mem [64];

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  ram_port_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) a_if ();
  ram_port_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) b_if ();

  ram_port_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .a(a_if), .b(b_if),
    .ram_mem_read(ram_mem_read), .ram_mem_write(ram_mem_write),
    .ram_addr(ram_addr), .ram_write_data(ram_write_data),
    .ram_read_data(ram_read_data), .busy(busy)
  );

  // Behavioural single-port RAM: combinational read, write on the rising edge.
  always @(posedge clk) if (ram_mem_write) mem[ram_addr] <= ram_write_data;
  assign ram_read_data = mem[ram_addr];

  task automatic wait_idle();
    for (int i = 0; i < 10 && busy; i++) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL wait_idle: busy=%b required 0", busy); end
  endtask

  task automatic issue(input logic port, input logic we, input logic [5:0] addr, input logic [15:0] wdata);
    if (!port) begin a_if.we = we; a_if.addr = addr; a_if.wdata = wdata; a_if.req = 1'b1; end
    else       begin b_if.we = we; b_if.addr = addr; b_if.wdata = wdata; b_if.req = 1'b1; end
  endtask

  // Waits up to 8 cycles for any ack; drops the acked port's req on the ack cycle.
  task automatic wait_ack(output int lat, output logic got_a, output logic got_b);
    lat = 0; got_a = 1'b0; got_b = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      lat++;
      if (a_if.ack || b_if.ack) begin
        got_a = a_if.ack; got_b = b_if.ack;
        if (got_a) a_if.req = 1'b0;
        if (got_b) b_if.req = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy, a_if.ack, b_if.ack, ram_mem_read, ram_mem_write} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl: busy/acks/strobes=%b required 00000",
                         {busy, a_if.ack, b_if.ack, ram_mem_read, ram_mem_write});
    end
    n_checks++;
    if ({a_if.rdata, b_if.rdata} !== 32'h0) begin
      n_fail++; $display("FAIL reset_rdata: a=%h b=%h required 0", a_if.rdata, b_if.rdata);
    end
    n_checks++;
    if ({ram_addr, ram_write_data} !== 22'h0) begin
      n_fail++; $display("FAIL reset_bus: addr=%h wdata=%h required 0", ram_addr, ram_write_data);
    end
  endtask

  task automatic test_write_read();
    exp_t e; int lat; logic ga, gb;
    wait_idle();
    issue(1'b0, 1'b1, 6'd5, 16'hBEEF);
    sb.push_back('{1'b0, 1'b0, 16'h0});
    @(negedge clk);
    n_checks++;
    if ({ram_mem_write, ram_mem_read, busy, a_if.ack} !== 4'b1010) begin
      n_fail++; $display("FAIL wr_access: wr/rd/busy/ack=%b required 1010",
                         {ram_mem_write, ram_mem_read, busy, a_if.ack});
    end
    n_checks++;
    if (ram_addr !== 6'd5 || ram_write_data !== 16'hBEEF) begin
      n_fail++; $display("FAIL wr_bus: addr=%0d wdata=%h required 5 beef", ram_addr, ram_write_data);
    end
    @(negedge clk);
    e = sb.pop_front();
    n_checks++;
    if ({a_if.ack, b_if.ack, ram_mem_write} !== {~e.port, e.port, 1'b0}) begin
      n_fail++; $display("FAIL wr_ack: a/b/wr=%b required %b", {a_if.ack, b_if.ack, ram_mem_write},
                         {~e.port, e.port, 1'b0});
    end
    a_if.req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (a_if.ack !== 1'b0 || ram_addr !== 6'd5 || mem[5] !== 16'hBEEF) begin
      n_fail++; $display("FAIL wr_after: ack=%b addr=%0d mem5=%h required 0 5 beef", a_if.ack, ram_addr, mem[5]);
    end
    wait_idle();
    issue(1'b0, 1'b0, 6'd5, 16'h0);
    sb.push_back('{1'b0, 1'b1, 16'hBEEF});
    wait_ack(lat, ga, gb);
    e = sb.pop_front();
    n_checks++;
    if (lat !== 2 || {ga, gb} !== {~e.port, e.port}) begin
      n_fail++; $display("FAIL rd_ack: lat=%0d a/b=%b required 2 %b", lat, {ga, gb}, {~e.port, e.port});
    end
    n_checks++;
    if (a_if.rdata !== e.data || b_if.rdata !== 16'h0) begin
      n_fail++; $display("FAIL rd_data: a=%h b=%h required %h 0000", a_if.rdata, b_if.rdata, e.data);
    end
  endtask

  task automatic test_b_read();
    exp_t e; int lat; logic ga, gb;
    wait_idle();
    issue(1'b1, 1'b0, 6'd63, 16'h0);
    sb.push_back('{1'b1, 1'b1, 16'h1234});
    wait_ack(lat, ga, gb);
    e = sb.pop_front();
    n_checks++;
    if (lat !== 2 || {ga, gb} !== {~e.port, e.port}) begin
      n_fail++; $display("FAIL b_ack: lat=%0d a/b=%b required 2 %b", lat, {ga, gb}, {~e.port, e.port});
    end
    n_checks++;
    if (b_if.rdata !== e.data || a_if.rdata !== 16'hBEEF) begin
      n_fail++; $display("FAIL b_data: b=%h a=%h required %h beef", b_if.rdata, a_if.rdata, e.data);
    end
  endtask

  task automatic test_simultaneous();
    exp_t e; int lat, ta, tb; logic ga, gb;
    ta = -1; tb = -1; lat = 0;
    wait_idle();
    issue(1'b0, 1'b1, 6'd10, 16'h0001);
    issue(1'b1, 1'b1, 6'd10, 16'h0002);
    sb.push_back('{1'b0, 1'b0, 16'h0});
    sb.push_back('{1'b1, 1'b0, 16'h0});
    for (int i = 0; i < 12 && (ta < 0 || tb < 0); i++) begin
      @(negedge clk);
      lat++;
      if (a_if.ack || b_if.ack) begin
        e = sb.pop_front();
        n_checks++;
        if (b_if.ack !== e.port || a_if.ack === b_if.ack) begin
          n_fail++; $display("FAIL sim_order: a/b=%b required %b", {a_if.ack, b_if.ack}, {~e.port, e.port});
        end
        if (a_if.ack) begin ta = lat; a_if.req = 1'b0; end
        if (b_if.ack) begin tb = lat; b_if.req = 1'b0; end
      end
    end
    n_checks++;
    if (ta !== 2 || tb !== 5) begin
      n_fail++; $display("FAIL sim_timing: a_ack@%0d b_ack@%0d required 2 5", ta, tb);
    end
    wait_idle();
    issue(1'b0, 1'b0, 6'd10, 16'h0);
    sb.push_back('{1'b0, 1'b1, 16'h0002});
    wait_ack(lat, ga, gb);
    e = sb.pop_front();
    n_checks++;
    if (!ga || a_if.rdata !== e.data) begin
      n_fail++; $display("FAIL sim_final: ack=%b rdata=%h required 1 %h", ga, a_if.rdata, e.data);
    end
  endtask

  task automatic test_arbitration_order();
    exp_t e; int seen;
    seen = 0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    issue(1'b0, 1'b0, 6'd5, 16'h0);
    issue(1'b1, 1'b0, 6'd63, 16'h0);
    for (int k = 0; k < 6; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
      sb.push_back('{logic'(k % 2), 1'b1, (k % 2) ? 16'h1234 : 16'hBEEF});
`else
      sb.push_back('{1'b0, 1'b1, 16'hBEEF});
`endif
    end
    for (int i = 0; i < 40 && seen < 6; i++) begin
      @(negedge clk);
      if (a_if.ack || b_if.ack) begin
        e = sb.pop_front();
        seen++;
        n_checks++;
        if ({a_if.ack, b_if.ack} !== {~e.port, e.port} ||
            (e.port ? b_if.rdata : a_if.rdata) !== e.data) begin
          n_fail++; $display("FAIL order_%0d: a/b=%b rdata a=%h b=%h required %b %h", seen,
                             {a_if.ack, b_if.ack}, a_if.rdata, b_if.rdata, {~e.port, e.port}, e.data);
        end
        if (seen == 6) begin a_if.req = 1'b0; b_if.req = 1'b0; end
      end
    end
    a_if.req = 1'b0; b_if.req = 1'b0;
    n_checks++;
    if (seen !== 6) begin n_fail++; $display("FAIL order_count: grants=%0d required 6", seen); end
    sb.delete();
  endtask

  task automatic test_reset_mid();
    int lat; logic ga, gb;
    wait_idle();
    issue(1'b0, 1'b1, 6'd7, 16'hFFFF);
    @(negedge clk);
    n_checks++;
    if (ram_mem_write !== 1'b1) begin n_fail++; $display("FAIL mid_access: wr=%b required 1", ram_mem_write); end
    reset = 1'b1;
    a_if.req = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy, a_if.ack} !== 2'b00 || mem[7] !== 16'h0000) begin
      n_fail++; $display("FAIL mid_reset: busy/ack=%b mem7=%h required 00 0000", {busy, a_if.ack}, mem[7]);
    end
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (a_if.ack !== 1'b0) begin n_fail++; $display("FAIL mid_noack: ack=%b required 0", a_if.ack); end
    wait_idle();
    issue(1'b0, 1'b0, 6'd7, 16'h0);
    sb.push_back('{1'b0, 1'b1, 16'h0000});
    wait_ack(lat, ga, gb);
    n_checks++;
    if (!ga || a_if.rdata !== sb[0].data) begin
      n_fail++; $display("FAIL mid_readback: ack=%b rdata=%h required 1 %h", ga, a_if.rdata, sb[0].data);
    end
    void'(sb.pop_front());
  endtask

  initial begin
    reset = 1'b1;
    a_if.req = 1'b0; a_if.we = 1'b0; a_if.addr = '0; a_if.wdata = '0;
    b_if.req = 1'b0; b_if.we = 1'b0; b_if.addr = '0; b_if.wdata = '0;
    for (int i = 0; i < 64; i++) mem[i] = 16'h0;
    mem[63] = 16'h1234;
    @(negedge clk);
    test_reset();
    test_write_read();
    test_b_read();
    test_simultaneous();
    test_arbitration_order();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
